// File: rtl/scancode_encoder.sv
// scancode_encoder: turns one key event into a serial stream of scan-code
// bytes (optional shift make, extended prefix, break prefix, code, optional
// shift break). One event is accepted only while idle.
// Optional feature macro: SCANCODE_SHIFT_WRAP_EN adds the i_ev_shift port and
// wraps the event in left-shift make/break bytes.
module scancode_encoder #(
  parameter logic [7:0] LSHIFT_CODE  = 8'h12,
  parameter logic [7:0] EXT_PREFIX   = 8'hE0,
  parameter logic [7:0] BREAK_PREFIX = 8'hF0
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_ev_valid,
  output logic       o_ev_ready,
  input  logic [7:0] i_ev_code,
  input  logic       i_ev_ext,
  input  logic       i_ev_brk,
`ifdef SCANCODE_SHIFT_WRAP_EN
  input  logic       i_ev_shift,
`endif
  output logic [7:0] o_byte,
  output logic       o_byte_en,
  input  logic       i_byte_rdy
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SH_MAKE     = 3'd1,
    EXT         = 3'd2,
    BRK         = 3'd3,
    CODE        = 3'd4,
    SH_BRK_F0   = 3'd5,
    SH_BRK_CODE = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       byte_en_q, byte_en_d;
  logic       ev_ready_q, ev_ready_d;
  logic       shift_s;
  logic       accept_s;
  logic       xfer_s;

`ifdef SCANCODE_SHIFT_WRAP_EN
  assign shift_s = i_ev_shift;
`else
  // Without the wrap feature shift is never requested, so the shift states
  // are unreachable.
  assign shift_s = 1'b0;
`endif

  assign accept_s = i_ev_valid & ev_ready_q;
  assign xfer_s   = byte_en_q & i_byte_rdy;

  assign o_ev_ready = ev_ready_q;
  assign o_byte     = byte_q;
  assign o_byte_en  = byte_en_q;

  // Capture the event fields on acceptance; later input changes are ignored.
  always_comb begin
    code_d  = code_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    shift_d = shift_q;
    if (accept_s) begin
      code_d  = i_ev_code;
      ext_d   = i_ev_ext;
      brk_d   = i_ev_brk;
      shift_d = shift_s;
    end else begin
      code_d  = code_q;
      ext_d   = ext_q;
      brk_d   = brk_q;
      shift_d = shift_q;
    end
  end

  // Next-state logic: each non-idle state advances only on a byte transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (shift_d && !brk_d) begin
            state_d = SH_MAKE;
          end else if (ext_d) begin
            state_d = EXT;
          end else if (brk_d) begin
            state_d = BRK;
          end else begin
            state_d = CODE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SH_MAKE: begin
        if (xfer_s) begin
          state_d = ext_q ? EXT : CODE;
        end else begin
          state_d = SH_MAKE;
        end
      end
      EXT: begin
        if (xfer_s) begin
          state_d = brk_q ? BRK : CODE;
        end else begin
          state_d = EXT;
        end
      end
      BRK: begin
        if (xfer_s) begin
          state_d = CODE;
        end else begin
          state_d = BRK;
        end
      end
      CODE: begin
        if (xfer_s) begin
          state_d = (shift_q && brk_q) ? SH_BRK_F0 : IDLE;
        end else begin
          state_d = CODE;
        end
      end
      SH_BRK_F0: begin
        if (xfer_s) begin
          state_d = SH_BRK_CODE;
        end else begin
          state_d = SH_BRK_F0;
        end
      end
      SH_BRK_CODE: begin
        if (xfer_s) begin
          state_d = IDLE;
        end else begin
          state_d = SH_BRK_CODE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered
  // while still lining up with the registered state.
  always_comb begin
    byte_d     = 8'h00;
    byte_en_d  = 1'b0;
    ev_ready_d = 1'b1;
    case (state_d)
      IDLE: begin
        byte_d     = 8'h00;
        byte_en_d  = 1'b0;
        ev_ready_d = 1'b1;
      end
      SH_MAKE: begin
        byte_d     = LSHIFT_CODE;
        byte_en_d  = 1'b1;
        ev_ready_d = 1'b0;
      end
      EXT: begin
        byte_d     = EXT_PREFIX;
        byte_en_d  = 1'b1;
        ev_ready_d = 1'b0;
      end
      BRK: begin
        byte_d     = BREAK_PREFIX;
        byte_en_d  = 1'b1;
        ev_ready_d = 1'b0;
      end
      CODE: begin
        byte_d     = code_d;
        byte_en_d  = 1'b1;
        ev_ready_d = 1'b0;
      end
      SH_BRK_F0: begin
        byte_d     = BREAK_PREFIX;
        byte_en_d  = 1'b1;
        ev_ready_d = 1'b0;
      end
      SH_BRK_CODE: begin
        byte_d     = LSHIFT_CODE;
        byte_en_d  = 1'b1;
        ev_ready_d = 1'b0;
      end
      default: begin
        byte_d     = 8'h00;
        byte_en_d  = 1'b0;
        ev_ready_d = 1'b1;
      end
    endcase
  end

  // State, captured fields and outputs; clear dominates accept and transfer.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q    <= IDLE;
      code_q     <= 8'h00;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      shift_q    <= 1'b0;
      byte_q     <= 8'h00;
      byte_en_q  <= 1'b0;
      ev_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      byte_en_q  <= byte_en_d;
      ev_ready_q <= ev_ready_d;
    end
  end

endmodule

// File: tb/tb_scancode_encoder.sv
// Self-checking bench for scancode_encoder: directed scenarios followed by
// random events, compared against a byte-queue reference model.
module tb_scancode_encoder;

  logic       clk;
  logic       i_sclr;
  logic       i_ev_valid;
  logic       o_ev_ready;
  logic [7:0] i_ev_code;
  logic       i_ev_ext;
  logic       i_ev_brk;
  logic       i_ev_shift;
  logic [7:0] o_byte;
  logic       o_byte_en;
  logic       i_byte_rdy;

  int n_checks;
  int n_fail;

  // Reference model: bytes still to be emitted for the current event.
  logic [7:0] model_q[$];

  scancode_encoder dut (
    .clk        (clk),
    .i_sclr     (i_sclr),
    .i_ev_valid (i_ev_valid),
    .o_ev_ready (o_ev_ready),
    .i_ev_code  (i_ev_code),
    .i_ev_ext   (i_ev_ext),
    .i_ev_brk   (i_ev_brk),
`ifdef SCANCODE_SHIFT_WRAP_EN
    .i_ev_shift (i_ev_shift),
`endif
    .o_byte     (o_byte),
    .o_byte_en  (o_byte_en),
    .i_byte_rdy (i_byte_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected byte list for one event, straight from the sequence rules.
  task automatic push_seq(input logic [7:0] c, input logic e, input logic b, input logic s);
    logic sh;
`ifdef SCANCODE_SHIFT_WRAP_EN
    sh = s;
`else
    sh = 1'b0;
    if (s) sh = 1'b0;
`endif
    if (sh && !b) model_q.push_back(8'h12);
    if (e)        model_q.push_back(8'hE0);
    if (b)        model_q.push_back(8'hF0);
    model_q.push_back(c);
    if (sh && b) begin
      model_q.push_back(8'hF0);
      model_q.push_back(8'h12);
    end
  endtask

  // One clock: check current outputs, drive inputs, advance model and clock.
  task automatic step(input logic v, input logic [7:0] c, input logic e, input logic b,
                      input logic s, input logic r, input logic cl);
    logic busy;
    busy = (model_q.size() != 0);
    check_eq("ev_ready", {31'd0, o_ev_ready}, {31'd0, !busy});
    check_eq("byte_en", {31'd0, o_byte_en}, {31'd0, busy});
    if (busy) check_eq("byte", {24'd0, o_byte}, {24'd0, model_q[0]});
    i_ev_valid = v;
    i_ev_code  = c;
    i_ev_ext   = e;
    i_ev_brk   = b;
    i_ev_shift = s;
    i_byte_rdy = r;
    i_sclr     = cl;
    if (cl) begin
      model_q.delete();
    end else if (busy) begin
      if (r) void'(model_q.pop_front());
    end else if (v) begin
      push_seq(c, e, b, s);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    i_sclr     = 1'b1;
    i_ev_valid = 1'b0;
    i_ev_code  = 8'h00;
    i_ev_ext   = 1'b0;
    i_ev_brk   = 1'b0;
    i_ev_shift = 1'b0;
    i_byte_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_sclr = 1'b0;
    check_eq("rst_byte", {24'd0, o_byte}, 32'd0);
    check_eq("rst_en", {31'd0, o_byte_en}, 32'd0);
    check_eq("rst_ready", {31'd0, o_ev_ready}, 32'd1);

    // Plain make, then idle with downstream ready.
    step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_steps(3);

    // Extended break, back-to-back bytes.
    step(1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_steps(4);

    // Shift-wrapped make then break (plain sequences without the feature).
    step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_steps(3);
    step(1'b1, 8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_steps(6);

    // Stall on the second byte; new valid events must be ignored.
    step(1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_steps(4);

    // Abort mid-sequence, then a fresh make.
    step(1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h29, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_steps(3);

    // Clear coinciding with a valid offer in idle wins.
    step(1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_steps(2);

    // Literal codes that look like prefixes.
    step(1'b1, 8'hE0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle_steps(3);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_steps(3);

    // Valid held with ready held: one idle cycle between sequences.
    for (int k = 0; k < 12; k++) step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_steps(3);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 1) == 1),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 99) < 2));
    end
    idle_steps(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
